// File: rtl/cpsr_unit.sv
// Architectural CPSR holder: single-cycle and multi-cycle NZCV commits, MSR byte-lane writes,
// and a pending-flag scoreboard that stalls dependent conditional instructions.
//   state  | meaning
//   S_IDLE | flags resolved; ALU flag commits and MSR writes accepted
//   S_PEND | multi-cycle flag write outstanding; hazard raised, MSR held off
module cpsr_unit #(
    parameter logic [31:0] RESET_CPSR   = 32'h0000_00D3,
    parameter int          PEND_TIMEOUT = 64,
    parameter int          CNT_W        = 7
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        set_cond_bits,
    input  logic        cond_go,
    input  logic        ex_multicycle,
    input  logic [3:0]  alu_flags,
    input  logic        mc_flags_valid,
    input  logic [3:0]  mc_flags,
    input  logic        msr_we,
    input  logic [3:0]  msr_mask,
    input  logic [31:0] msr_data,
    output logic [31:0] cpsr,
    output logic        cpsr_hazard,
    output logic        msr_ready,
    output logic        pend_err
);

    typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

    localparam logic [CNT_W-1:0] L_TIMEOUT    = CNT_W'(PEND_TIMEOUT);
    localparam logic [CNT_W-1:0] L_TIMEOUT_M1 = CNT_W'(PEND_TIMEOUT - 1);

    state_t           r_state;
    logic [31:0]      r_cpsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_err;

    logic             w_adv;
    logic [31:0]      w_msr_cpsr;

    assign w_adv = ex_valid & ~ex_stall & ~ex_flush & cond_go & set_cond_bits;

    always_comb begin
        w_msr_cpsr = r_cpsr;
        for (int i = 0; i < 4; i++) begin
            if (msr_mask[i]) w_msr_cpsr[8*i +: 8] = msr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_cpsr     <= RESET_CPSR;
            r_cnt      <= '0;
            r_pend_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Flag commit owns 31:28; MSR still lands in the remaining lanes.
                    if (w_adv && !ex_multicycle) begin
                        r_cpsr <= {alu_flags, (msr_we ? w_msr_cpsr[27:0] : r_cpsr[27:0])};
                    end else if (msr_we) begin
                        r_cpsr <= w_msr_cpsr;
                    end
                    if (w_adv && ex_multicycle) begin
                        r_state <= S_PEND;
                        r_cnt   <= '0;
                    end
                end
                S_PEND: begin
                    if (r_cnt != L_TIMEOUT) r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == L_TIMEOUT_M1) r_pend_err <= 1'b1;
                    // Producer has already left execute, so its flags commit even on a flush.
                    if (mc_flags_valid) begin
                        r_cpsr[31:28] <= mc_flags;
                        r_state       <= S_IDLE;
                    end else if (ex_flush) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpsr        = r_cpsr;
    assign cpsr_hazard = (r_state == S_PEND);
    assign msr_ready   = (r_state == S_IDLE);
    assign pend_err    = r_pend_err;

endmodule

// File: tb/tb_cpsr_unit.sv
// Directed bench for cpsr_unit: flag commits, pending scoreboard, flush, MSR merge, timeout, reset.
module tb_cpsr_unit;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ex_valid, ex_stall, ex_flush, set_cond_bits, cond_go, ex_multicycle;
    logic [3:0]  alu_flags, mc_flags, msr_mask;
    logic        mc_flags_valid, msr_we;
    logic [31:0] msr_data;
    logic [31:0] cpsr;
    logic        cpsr_hazard, msr_ready, pend_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_haz;

    cpsr_unit #(
        .RESET_CPSR  (32'h0000_00D3),
        .PEND_TIMEOUT(64),
        .CNT_W       (7)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_flush      (ex_flush),
        .set_cond_bits (set_cond_bits),
        .cond_go       (cond_go),
        .ex_multicycle (ex_multicycle),
        .alu_flags     (alu_flags),
        .mc_flags_valid(mc_flags_valid),
        .mc_flags      (mc_flags),
        .msr_we        (msr_we),
        .msr_mask      (msr_mask),
        .msr_data      (msr_data),
        .cpsr          (cpsr),
        .cpsr_hazard   (cpsr_hazard),
        .msr_ready     (msr_ready),
        .pend_err      (pend_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_stall = 0; ex_flush = 0; set_cond_bits = 0; cond_go = 0;
        ex_multicycle = 0; alu_flags = 4'h0; mc_flags_valid = 0; mc_flags = 4'h0;
        msr_we = 0; msr_mask = 4'h0; msr_data = 32'h0;
    endtask

    task automatic drive_adv(input logic mc, input logic [3:0] flags);
        ex_valid = 1; set_cond_bits = 1; cond_go = 1; ex_multicycle = mc; alu_flags = flags;
    endtask

    initial begin
        idle_inputs();
        rst_b = 0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1;
        #1;
        chk("rst_cpsr", cpsr, 32'h0000_00D3);
        chk("rst_haz", {31'b0, cpsr_hazard}, 32'd0);
        chk("rst_rdy", {31'b0, msr_ready}, 32'd1);
        chk("rst_err", {31'b0, pend_err}, 32'd0);

        // single-cycle commit, visible only after the edge
        drive_adv(0, 4'b0100);
        #1 chk("no_bypass", cpsr, 32'h0000_00D3);
        step(); idle_inputs();
        chk("alu_commit", cpsr, 32'h4000_00D3);

        drive_adv(0, 4'b1111); cond_go = 0;
        step(); idle_inputs();
        chk("cond_fail", cpsr, 32'h4000_00D3);
        drive_adv(0, 4'b1111); ex_stall = 1;
        step(); idle_inputs();
        chk("stalled", cpsr, 32'h4000_00D3);
        mc_flags_valid = 1; mc_flags = 4'b1111;
        step(); idle_inputs();
        chk("mc_in_idle", cpsr, 32'h4000_00D3);

        // multi-cycle: valid arrives in the 4th hazard cycle
        n_haz = 0;
        drive_adv(1, 4'b1111);
        step(); idle_inputs();
        chk("pend_cpsr", cpsr, 32'h4000_00D3);
        for (int k = 0; k < 3; k++) begin
            if (cpsr_hazard) n_haz++;
            chk("pend_rdy", {31'b0, msr_ready}, 32'd0);
            msr_we = (k == 1); msr_mask = 4'hF; msr_data = 32'h0;
            step(); idle_inputs();
        end
        chk("msr_blocked", cpsr, 32'h4000_00D3);
        if (cpsr_hazard) n_haz++;
        mc_flags_valid = 1; mc_flags = 4'b1001;
        step(); idle_inputs();
        if (cpsr_hazard) n_haz++;
        chk("haz_len", 32'(n_haz), 32'd4);
        chk("mc_commit", cpsr, 32'h9000_00D3);
        chk("mc_rdy", {31'b0, msr_ready}, 32'd1);

        // flush discards pending write
        drive_adv(1, 4'h0);
        step(); idle_inputs();
        chk("fl_haz1", {31'b0, cpsr_hazard}, 32'd1);
        step();
        ex_flush = 1;
        step(); idle_inputs();
        chk("fl_haz0", {31'b0, cpsr_hazard}, 32'd0);
        chk("fl_cpsr", cpsr, 32'h9000_00D3);
        mc_flags_valid = 1; mc_flags = 4'b0110;
        step(); idle_inputs();
        chk("fl_late_mc", cpsr, 32'h9000_00D3);

        // flush with valid flags: commit wins
        drive_adv(1, 4'h0);
        step(); idle_inputs();
        ex_flush = 1; mc_flags_valid = 1; mc_flags = 4'b0011;
        step(); idle_inputs();
        chk("fl_mc_cpsr", cpsr, 32'h3000_00D3);
        chk("fl_mc_haz", {31'b0, cpsr_hazard}, 32'd0);

        // same-cycle ALU commit and MSR
        drive_adv(0, 4'b0010);
        msr_we = 1; msr_mask = 4'b1001; msr_data = 32'hF5AA_AA1F;
        step(); idle_inputs();
        chk("alu_msr", cpsr, 32'h2500_001F);
        msr_we = 1; msr_mask = 4'b0110; msr_data = 32'h1234_5678;
        step(); idle_inputs();
        chk("msr_only", cpsr, 32'h2534_561F);

        // timeout
        drive_adv(1, 4'h0);
        step(); idle_inputs();
        repeat (63) step();
        chk("to_err63", {31'b0, pend_err}, 32'd0);
        step();
        chk("to_err64", {31'b0, pend_err}, 32'd1);
        chk("to_haz", {31'b0, cpsr_hazard}, 32'd1);
        mc_flags_valid = 1; mc_flags = 4'b1000;
        step(); idle_inputs();
        chk("to_sticky", {31'b0, pend_err}, 32'd1);
        chk("to_commit", cpsr, 32'h8534_561F);

        // async reset mid-PEND
        drive_adv(1, 4'h0);
        step(); idle_inputs();
        step();
        rst_b = 0;
        #1;
        chk("ar_haz", {31'b0, cpsr_hazard}, 32'd0);
        chk("ar_rdy", {31'b0, msr_ready}, 32'd1);
        chk("ar_cpsr", cpsr, 32'h0000_00D3);
        chk("ar_err", {31'b0, pend_err}, 32'd0);
        step();
        rst_b = 1;
        mc_flags_valid = 1; mc_flags = 4'b1111;
        step(); idle_inputs();
        chk("ar_no_commit", cpsr, 32'h0000_00D3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpsr_unit.md
Name: cpsr_unit

Overview:
- Holds the architectural CPSR and drives the `cpsr` input of the condition-evaluation stage.
- Consumes that stage's `set_cond_bits` and `cond_go`, together with NZCV results from single-cycle and multi-cycle execute units.
- Also supports MSR-style masked writes.
- Scoreboards a pending flag write from a multi-cycle unit and raises a hazard so that dependent conditional instructions stall until the flags resolve.

Parameters:
- RESET_CPSR, 32'h0000_00D3, value loaded into the CPSR on reset.
- PEND_TIMEOUT, 64, maximum cycles in PEND before the sticky error is set; must be ≥2.
- CNT_W, 7, width of the pending-cycle counter; must satisfy 2^CNT_W > PEND_TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage holds a valid instruction this cycle.
- ex_stall  in  1  execute stage is stalled; instruction does not advance.
- ex_flush  in  1  execute stage contents are killed this cycle.
- set_cond_bits  in  1  instruction in execute updates NZCV (already qualified by cond_go).
- cond_go  in  1  instruction in execute passes its condition.
- ex_multicycle  in  1  flags for this instruction come later on mc_flags.
- alu_flags  in  4  NZCV from single-cycle ALU, {N,Z,C,V}.
- mc_flags_valid  in  1  multi-cycle unit presents final flags this cycle.
- mc_flags  in  4  NZCV from multi-cycle unit.
- msr_we  in  1  MSR write request.
- msr_mask  in  4  byte-lane enables, bit i selects cpsr[8i+7:8i].
- msr_data  in  32  MSR write data.
- cpsr  out  32  registered CPSR (N=31, Z=30, C=29, V=28).
- cpsr_hazard  out  1  flags pending; condition evaluation must stall.
- msr_ready  out  1  MSR write accepted this cycle.
- pend_err  out  1  sticky; pending flag write exceeded PEND_TIMEOUT.

Behaviour:
- Reset (rst_b low, asynchronous):
  - cpsr = RESET_CPSR; state = IDLE; pend counter = 0; pend_err = 0.
  - Combinational outputs follow the reset state: cpsr_hazard = 0, msr_ready = 1.
- Reset asserted mid-PEND discards the pending write.
- Define `adv` = ex_valid & ~ex_stall & ~ex_flush & cond_go & set_cond_bits.
- States: IDLE, PEND.
- IDLE:
  - cpsr_hazard = 0; msr_ready = 1.
  - adv & ~ex_multicycle: cpsr[31:28] <= alu_flags at the edge. Stay IDLE. The new value is visible the next cycle (1-cycle latency, no combinational bypass).
  - adv & ex_multicycle: go to PEND, clear the counter. cpsr unchanged.
  - mc_flags_valid in IDLE is ignored.
- PEND:
  - cpsr_hazard = 1; msr_ready = 0 (MSR requests are not accepted and must be held by the requester).
  - Counter increments each cycle, saturating at PEND_TIMEOUT.
  - mc_flags_valid: cpsr[31:28] <= mc_flags; go to IDLE. cpsr_hazard drops the following cycle.
  - ex_flush without mc_flags_valid: discard the pending write; go to IDLE; cpsr unchanged.
  - ex_flush together with mc_flags_valid: the flags commit (the producing instruction already left execute); go to IDLE.
  - Counter reaches PEND_TIMEOUT: pend_err <= 1 (sticky until reset). Remain in PEND.
  - The `adv` term is ignored in PEND; upstream guarantees stall while cpsr_hazard = 1.
- MSR (IDLE only, msr_we & msr_ready):
  - For each i with msr_mask[i] set, cpsr[8i+7:8i] <= msr_data[8i+7:8i] at the edge.
- Same-cycle flag commit and MSR in IDLE:
  - The flag commit wins for bits 31:28.
  - MSR still writes bits 27:24 if msr_mask[3] is set, and all other enabled lanes.
- Flag writes touch only bits 31:28; bits 27:0 change only through MSR or reset.
- cpsr is driven directly from the state register, with no combinational path from any input.

Test Plan:
- Reset with RESET_CPSR=32'h0000_00D3, release rst_b -> cpsr=32'h0000_00D3, cpsr_hazard=0, msr_ready=1, pend_err=0.
- adv single-cycle with alu_flags=4'b0100 -> next cycle cpsr=32'h4000_00D3; same stimulus with cond_go=0 -> cpsr unchanged.
- adv with ex_multicycle=1, then mc_flags_valid=1 with mc_flags=4'b1001 three cycles later:
  - cpsr_hazard is high for exactly 4 cycles.
  - msr_ready=0 during that window.
  - cpsr=32'h9000_00D3 after the hazard drops.
- PEND, then ex_flush without mc_flags_valid -> IDLE, cpsr unchanged, cpsr_hazard=0 next cycle; a later mc_flags_valid is ignored.
- Same cycle in IDLE: adv with alu_flags=4'b0010, plus msr_we with mask=4'b1001 and data=32'hF5AA_AA1F:
  - cpsr = 32'h2500_00 with low byte 1F, i.e. 32'h2500_001F (byte 3 = 0x20 | 0x05, byte 0 = 0x1F).
- Enter PEND and hold without mc_flags_valid for PEND_TIMEOUT=64 cycles -> pend_err=1 on cycle 64 and stays 1 after later commit; assert rst_b low mid-PEND -> IDLE immediately, cpsr=RESET_CPSR, pend_err=0.
